// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Holds the OP encodings, the FSM state encodings and the default operand width.
package hilo_muldiv_pkg;

    localparam int unsigned N_DEF = 32;

    // Operation select (fully decoded, no illegal values)
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM states
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    // Signed ops convert operands to magnitudes and fix the sign at the end
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
// Ports:
//   is_div      - 1: restoring-divide step, 0: shift-add multiply step
//   acc         - upper half of product / partial remainder
//   low         - lower half of product (multiplier bits) / dividend-then-quotient bits
//   opd         - multiplicand / divisor magnitude
//   acc_next_c  - acc after this iteration
//   low_next_c  - low after this iteration
module muldiv_step #(
    parameter int unsigned N = 32
) (
    input  logic         is_div,
    input  logic [N-1:0] acc,
    input  logic [N-1:0] low,
    input  logic [N-1:0] opd,
    output logic [N-1:0] acc_next_c,
    output logic [N-1:0] low_next_c
);

    logic [N:0]   sum;       // multiply: upper half plus conditional addend, with carry
    logic [N:0]   shifted;   // divide: remainder shifted left with next dividend bit (guard bit on top)
    logic [N-1:0] rem;
    logic         no_borrow;

    always_comb begin
        sum        = {1'b0, acc} + (low[0] ? {1'b0, opd} : {(N+1){1'b0}});
        shifted    = {acc, low[N-1]};
        no_borrow  = (shifted >= {1'b0, opd});
        // When no borrow the true difference is below the divisor, so N bits suffice
        rem        = shifted[N-1:0] - opd;
        acc_next_c = acc;
        low_next_c = low;
        if (is_div) begin
            acc_next_c = no_borrow ? rem : shifted[N-1:0];
            low_next_c = {low[N-2:0], no_borrow};
        end else begin
            // Shift the whole 2N-bit product register right by one, carry included
            acc_next_c = sum[N:1];
            low_next_c = {sum[0], low[N-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start, op, a, b - launch MULT/MULTU/DIV/DIVU (sampled only while idle)
//   mthi, mtlo      - write wdata into HI / LO while idle
//   wdata           - data for mthi/mtlo
//   busy            - operation in progress
//   done            - one-cycle pulse when HI/LO hold a new result
//   hi, lo          - HI/LO registers
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int unsigned CW = $clog2(N);

    logic [1:0]    state,  state_nxt;
    logic [CW-1:0] cnt,    cnt_nxt;
    logic [1:0]    op_q,   op_nxt;
    logic [N-1:0]  acc,    acc_nxt;
    logic [N-1:0]  low,    low_nxt;
    logic [N-1:0]  opd,    opd_nxt;
    logic [N-1:0]  a_raw,  a_raw_nxt;
    logic          sa,     sa_nxt;
    logic          sb,     sb_nxt;
    logic          div0,   div0_nxt;
    logic [N-1:0]  hi_nxt, lo_nxt;
    logic          busy_nxt, done_nxt;

    logic [N-1:0]   step_acc_c;
    logic [N-1:0]   step_low_c;
    logic [2*N-1:0] prod_c;

    muldiv_step #(.N(N)) u_step (
        .is_div     (op_q[1]),
        .acc        (acc),
        .low        (low),
        .opd        (opd),
        .acc_next_c (step_acc_c),
        .low_next_c (step_low_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        acc_nxt   = acc;
        low_nxt   = low;
        opd_nxt   = opd;
        a_raw_nxt = a_raw;
        sa_nxt    = sa;
        sb_nxt    = sb;
        div0_nxt  = div0;
        hi_nxt    = hi;
        lo_nxt    = lo;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        prod_c    = {acc, low};

        case (state)
            S_IDLE: begin
                if (mthi) hi_nxt = wdata;
                if (mtlo) lo_nxt = wdata;
                if (start) begin
                    op_nxt    = op;
                    sa_nxt    = op_is_signed(op) & a[N-1];
                    sb_nxt    = op_is_signed(op) & b[N-1];
                    low_nxt   = (op_is_signed(op) && a[N-1]) ? -a : a;
                    opd_nxt   = (op_is_signed(op) && b[N-1]) ? -b : b;
                    acc_nxt   = '0;
                    a_raw_nxt = a;
                    div0_nxt  = (b == '0);
                    cnt_nxt   = CW'(N - 1);
                    busy_nxt  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                acc_nxt = step_acc_c;
                low_nxt = step_low_c;
                if (cnt == '0) state_nxt = S_FIX;
                else           cnt_nxt   = cnt - CW'(1);
            end
            S_FIX: begin
                case (op_q)
                    OP_MULT, OP_MULTU: begin
                        prod_c = (sa ^ sb) ? -{acc, low} : {acc, low};
                        hi_nxt = prod_c[2*N-1:N];
                        lo_nxt = prod_c[N-1:0];
                    end
                    OP_DIV, OP_DIVU: begin
                        if (div0) begin
                            hi_nxt = a_raw;
                            lo_nxt = '1;
                        end else begin
                            // Quotient truncates toward zero; remainder follows the dividend
                            lo_nxt = (sa ^ sb) ? -low : low;
                            hi_nxt = sa ? -acc : acc;
                        end
                    end
                    default: ;
                endcase
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            acc   <= '0;
            low   <= '0;
            opd   <= '0;
            a_raw <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            acc   <= acc_nxt;
            low   <= low_nxt;
            opd   <= opd_nxt;
            a_raw <= a_raw_nxt;
            sa    <= sa_nxt;
            sb    <= sb_nxt;
            div0  <= div0_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected HI/LO and completion time,
// a negedge monitor pops and compares on every DONE pulse.
module tb_hilo_muldiv;

    localparam logic [1:0] T_MULT = 2'b00, T_MULTU = 2'b01, T_DIV = 2'b10, T_DIVU = 2'b11;
    localparam time PER = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        time         t;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hilo_muldiv #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #(PER/2) clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results {HI, LO} from plain arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint      sa_, sb_, qq, rr;
        logic [63:0] p;
        logic [31:0] uq, ur;
        p = '0;
        case (o)
            T_MULT: begin
                sa_ = longint'($signed(av));
                sb_ = longint'($signed(bv));
                p   = 64'(sa_ * sb_);
            end
            T_MULTU: p = {32'b0, av} * {32'b0, bv};
            T_DIV: begin
                if (bv == 32'd0) p = {av, 32'hFFFF_FFFF};
                else begin
                    sa_ = longint'($signed(av));
                    sb_ = longint'($signed(bv));
                    qq  = sa_ / sb_;
                    rr  = sa_ % sb_;
                    p   = {rr[31:0], qq[31:0]};
                end
            end
            default: begin
                if (bv == 32'd0) p = {av, 32'hFFFF_FFFF};
                else begin
                    uq = av / bv;
                    ur = av % bv;
                    p  = {ur, uq};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Waits for idle, launches one op and records the expected result
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        int          g;
        logic [63:0] r;
        exp_t        e;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("issue_wait_busy", 64'(busy), 64'd0);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        r     = ref_model(o, av, bv);
        @(posedge clk);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.t  = $time + 33 * PER + PER / 2;
        q.push_back(e);
        #1 start = 1'b0;
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = q.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("done_time", 64'($time), 64'(e.t));
            end
        end
    end

    initial begin
        logic [31:0] lo_prev;
        int          g;

        #1;
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULTU all-ones, with busy profile through the run
        issue(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            check("busy_run", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("busy_after", 64'(busy), 64'd0);

        issue(T_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        issue(T_DIV,  32'hFFFF_FFF9, 32'h0000_0002);
        issue(T_DIVU, 32'd7, 32'd2);
        issue(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        issue(T_DIVU, 32'h1234_5678, 32'd0);
        issue(T_DIV,  32'h8765_4321, 32'd0);

        // MTHI while idle
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        lo_prev = lo;
        mthi  = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h0000_0000_CAFE_F00D);
        check("mthi_lo", 64'(lo), 64'(lo_prev));

        // MTLO and a second START during a run are both ignored
        issue(T_MULTU, 32'd2, 32'd3);
        repeat (5) @(negedge clk);
        lo_prev = lo;
        mtlo  = 1'b1;
        wdata = 32'h0000_0001;
        start = 1'b1;
        op    = T_DIV;
        a     = $urandom;
        b     = $urandom;
        @(posedge clk);
        #1;
        mtlo  = 1'b0;
        start = 1'b0;
        check("mtlo_busy_lo", 64'(lo), 64'(lo_prev));
        check("mtlo_busy_busy", 64'(busy), 64'd1);

        // Randomized back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd());
        end

        // Reset in the middle of a MULTU aborts it with no result
        issue(T_MULTU, $urandom, $urandom);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", 64'(busy), 64'd0);
        check("abort_idle_lo",   64'(lo),   64'd0);

        // Recovery after the abort
        issue(T_MULT, $urandom, $urandom);
        issue(T_DIVU, $urandom, 32'($urandom_range(1, 255)));

        g = 0;
        while (q.size() > 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle integer multiply/divide unit that owns the MIPS HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits in EX beside the ALU.
- HI and LO feed the writeback-select 2:1 mux, which picks between ALU result and HI/LO for MFHI/MFLO.
- BUSY goes to the hazard unit, which stalls MFHI/MFLO and new mult/div ops while an operation runs.

Parameters:
- N, 32, operand width; HI and LO are each N bits; iteration count = N.

Ports:
- CLK  input  1  clock, all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  launch the operation selected by OP; sampled only when BUSY=0.
- OP  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  N  multiplicand / dividend (rs).
- B  input  N  multiplier / divisor (rt).
- MTHI  input  1  write WDATA into HI.
- MTLO  input  1  write WDATA into LO.
- WDATA  input  N  data for MTHI/MTLO.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse in the cycle HI/LO hold a new result.
- HI  output  N  HI register.
- LO  output  N  LO register.

Behaviour:
- Reset (async, RST_N=0): HI=0, LO=0, BUSY=0, DONE=0, state IDLE, iteration counter=0. Reset asserted mid-operation aborts the operation and leaves no partial result.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - START=1 at edge E0: latch OP; latch |A| and |B| for signed ops (raw values for unsigned); latch the sign flags.
  - Counter loads N-1; go to RUN; BUSY=1 after E0.
- RUN, one iteration per edge, E1..EN:
  - Multiply: shift-add, 2N-bit product register.
  - Divide: restoring; one quotient bit per edge; N-bit remainder plus one guard bit.
  - Go to FIX when the counter reaches 0.
- FIX, edge E(N+1):
  - Apply the sign fixup and load HI/LO.
  - DONE=1 and BUSY=0 for the following cycle; return to IDLE.
  - DONE clears after E(N+2) unless a new operation completes.
- Latency: result visible N+1 edges after the START edge (33 for N=32).
- START is accepted again in the DONE cycle.
- Multiply results: HI = product[2N-1:N], LO = product[N-1:0]. MULT product is two's-complement signed; MULTU is unsigned.
- Divide results: LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (B=0): detected at START.
  - Still runs the full N+1 latency.
  - Result: LO = all ones, HI = A (the original, unconverted dividend) for both DIV and DIVU.
- Signed overflow: DIV with A = 0x80000000, B = 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This falls out of two's-complement wrap.
- START while BUSY=1: ignored, with no effect on the running operation.
- MTHI/MTLO:
  - When BUSY=0: target register takes WDATA at the next edge.
  - Both asserted: both registers take WDATA.
  - Ignored while BUSY=1.
  - Same edge as an accepted START: the move is applied, and the op result overwrites it at FIX.
- OP values are decoded fully; there are no illegal encodings.

Decomposition:
- Shared package/header holds:
  - OP encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state encodings: S_IDLE, S_RUN, S_FIX.
- One natural sub-module, muldiv_step: combinational single-iteration datapath (add-shift step for multiply, subtract-compare step for divide), instantiated once.
- Top level holds the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF, START at E0 -> HI=0xFFFFFFFE, LO=0x00000001, DONE=1 exactly after E33; BUSY=1 during E1..E33 cycles.
- MULT A=0xFFFFFFFD (-3) B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7) B=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7 B=2 -> LO=3, HI=1. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x12345678 B=0 -> LO=0xFFFFFFFF, HI=0x12345678, DONE after E33.
- MTHI WDATA=0xCAFEF00D while idle -> HI=0xCAFEF00D next edge, LO unchanged. Then start MULTU 2x3; MTLO 0x1 and a second START mid-run -> both ignored; final HI=0, LO=6.
- MULTU in progress, RST_N pulled low at cycle 10 (between edges) -> HI=0, LO=0, BUSY=0, DONE=0 immediately. After release, no DONE pulse ever appears for the aborted op.
